obj_det_capture_ctrl: RTL and testbench

- Sits directly upstream of the object-detection datapath and drives all of its inputs.
- Binarizes the camera luma stream into a 1-bit pixel, generates the 17-bit frame-buffer addresses and the write/enable strobes for the reference and difference BRAMs, and emits `frame_start` and `init_done`.
- Sequences power-up settling, reference-frame capture, run mode and operator-requested re-capture.

---
 rtl/obj_det_pkg.sv | 18 +
 rtl/obj_det_capture_ctrl_if.sv | 36 +++
 rtl/obj_det_pix_counter.sv | 36 +++
 rtl/obj_det_capture_ctrl.sv | 148 ++++++++++++++
 tb/tb_obj_det_capture_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/obj_det_pkg.sv
// Shared constants and state encoding for the object-detection
// capture controller.
package obj_det_pkg;

  localparam int H_ACTIVE    = 320;
  localparam int V_ACTIVE    = 240;
  localparam int PIX_COUNT   = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W      = 17;
  localparam int SKIP_FRAMES = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE      = 2'd1,
    CAPTURE_REF = 2'd2,
    RUN         = 2'd3
  } state_e;

endpackage

// File: rtl/obj_det_capture_ctrl_if.sv
// Camera-in / frame-buffer-out bundle of the capture controller.
// master = controller side, slave = camera + datapath side.
interface obj_det_capture_ctrl_if #(
  parameter int ADDR_W = 17
);

  logic              cam_vsync;
  logic              cam_valid;
  logic [7:0]        cam_luma;
  logic              pixel_out;
  logic [ADDR_W-1:0] ref_addr;
  logic [ADDR_W-1:0] diff_addr;
  logic              ref_wren;
  logic              ref_bram_enable;
  logic              diff_wren;
  logic              diff_bram_enable;
  logic              frame_start;
  logic              init_done;

  modport master (
    input  cam_vsync, cam_valid, cam_luma,
    output pixel_out, ref_addr, diff_addr,
    output ref_wren, ref_bram_enable,
    output diff_wren, diff_bram_enable,
    output frame_start, init_done
  );

  modport slave (
    output cam_vsync, cam_valid, cam_luma,
    input  pixel_out, ref_addr, diff_addr,
    input  ref_wren, ref_bram_enable,
    input  diff_wren, diff_bram_enable,
    input  frame_start, init_done
  );

endinterface

// File: rtl/obj_det_pix_counter.sv
// Per-frame pixel counter, saturating at PIX_COUNT; a frame
// boundary restarts it in the same cycle.
module obj_det_pix_counter #(
  parameter int PIX_COUNT = 76800,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_rise,
  input  logic              cam_valid,
  output logic              accept,
  output logic              overrun,
  output logic              full,
  output logic [ADDR_W-1:0] addr
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] PIX = CW'(PIX_COUNT);

  logic [CW-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base    = vs_rise ? '0 : cnt_q;
    accept  = cam_valid && (base < PIX);
    overrun = cam_valid && !accept;
    cnt_d   = accept ? base + 1'b1 : base;
    addr    = base[ADDR_W-1:0];
    full    = (cnt_q == PIX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/obj_det_capture_ctrl.sv
// Capture controller: settle, reference capture, run and
// re-capture sequencing plus BRAM strobe generation.
module obj_det_capture_ctrl #(
  parameter int H_ACTIVE    = obj_det_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = obj_det_pkg::V_ACTIVE,
  parameter int PIX_COUNT   = H_ACTIVE * V_ACTIVE,
  parameter int ADDR_W      = obj_det_pkg::ADDR_W,
  parameter int SKIP_FRAMES = obj_det_pkg::SKIP_FRAMES
) (
  input  logic                          pixel_clk,
  input  logic                          reset,
  obj_det_capture_ctrl_if.master        bus,
  input  logic [7:0]                    luma_thres,
  input  logic                          recapture_req,
  input  logic                          err_clr,
  output logic [1:0]                    state_out,
  output logic                          short_frame_err,
  output logic                          overrun_err
);

  import obj_det_pkg::*;

  logic              vs_q, vs_prev_q, vs_rise;
  state_e            state_q, state_d;
  logic [7:0]        skip_q, skip_d;
  logic              pend_q, pend_d;
  logic              accept, overrun, full;
  logic [ADDR_W-1:0] pix_addr, addr_q, addr_d;
  logic              ref_wren_q, ref_wren_d;
  logic              ref_en_q, ref_en_d;
  logic              diff_wren_q, diff_wren_d;
  logic              pix_q, pix_d;
  logic              fs_q, fs_d;
  logic              init_q, init_d;
  logic              short_q, short_d;
  logic              ovr_q, ovr_d;
  logic              active;

  assign vs_rise = vs_q & ~vs_prev_q;

  obj_det_pix_counter #(
    .PIX_COUNT (PIX_COUNT),
    .ADDR_W    (ADDR_W)
  ) u_cnt (
    .clk       (pixel_clk),
    .rst       (reset),
    .vs_rise   (vs_rise),
    .cam_valid (bus.cam_valid),
    .accept    (accept),
    .overrun   (overrun),
    .full      (full),
    .addr      (pix_addr)
  );

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    pend_d  = pend_q;
    if (state_q == RUN && recapture_req) pend_d = 1'b1;
    if (vs_rise) begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
          skip_d  = '0;
        end
        SETTLE: begin
          skip_d = skip_q + 8'd1;
          if (skip_d == 8'(SKIP_FRAMES)) state_d = CAPTURE_REF;
        end
        CAPTURE_REF: begin
          if (full) state_d = RUN;
        end
        RUN: begin
          if (pend_q) begin
            state_d = CAPTURE_REF;
            pend_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A pixel arriving with the boundary belongs to the new state
    active      = (state_d == CAPTURE_REF) || (state_d == RUN);
    ref_wren_d  = (state_d == CAPTURE_REF) && accept;
    ref_en_d    = active && accept;
    diff_wren_d = (state_d == RUN) && accept;
    addr_d      = accept ? pix_addr : addr_q;
    pix_d       = active && (bus.cam_luma >= luma_thres);
    fs_d        = vs_rise && (state_d != IDLE);
    init_d      = (state_d == RUN);

    // Entry boundary is judged in the previous state, so never flags
    short_d = err_clr ? 1'b0 : short_q;
    if (vs_rise && (state_q == CAPTURE_REF || state_q == RUN) && !full)
      short_d = 1'b1;
    ovr_d = err_clr ? 1'b0 : ovr_q;
    if (overrun) ovr_d = 1'b1;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      skip_q      <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      ref_wren_q  <= 1'b0;
      ref_en_q    <= 1'b0;
      diff_wren_q <= 1'b0;
      pix_q       <= 1'b0;
      fs_q        <= 1'b0;
      init_q      <= 1'b0;
      short_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      vs_q        <= bus.cam_vsync;
      vs_prev_q   <= vs_q;
      state_q     <= state_d;
      skip_q      <= skip_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      ref_wren_q  <= ref_wren_d;
      ref_en_q    <= ref_en_d;
      diff_wren_q <= diff_wren_d;
      pix_q       <= pix_d;
      fs_q        <= fs_d;
      init_q      <= init_d;
      short_q     <= short_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.pixel_out        = pix_q;
  assign bus.ref_addr         = addr_q;
  assign bus.diff_addr        = addr_q;
  assign bus.ref_wren         = ref_wren_q;
  assign bus.ref_bram_enable  = ref_en_q;
  assign bus.diff_wren        = diff_wren_q;
  assign bus.diff_bram_enable = diff_wren_q;
  assign bus.frame_start      = fs_q;
  assign bus.init_done        = init_q;
  assign state_out            = state_q;
  assign short_frame_err      = short_q;
  assign overrun_err          = ovr_q;

endmodule

// File: tb/tb_obj_det_capture_ctrl.sv
// Directed bench for obj_det_capture_ctrl on a reduced 8x4 frame.
module tb_obj_det_capture_ctrl;

  localparam int PIX = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] thr;
  logic       rcq;
  logic       eclr;
  logic [1:0] st;
  logic       serr;
  logic       oerr;

  int checks = 0;
  int errors = 0;
  int nref   = 0;
  int ndiff  = 0;
  int nfs    = 0;

  obj_det_capture_ctrl_if #(.ADDR_W(17)) bus ();

  obj_det_capture_ctrl #(
    .H_ACTIVE    (8),
    .V_ACTIVE    (4),
    .ADDR_W      (17),
    .SKIP_FRAMES (4)
  ) dut (
    .pixel_clk       (clk),
    .reset           (rst),
    .bus             (bus),
    .luma_thres      (thr),
    .recapture_req   (rcq),
    .err_clr         (eclr),
    .state_out       (st),
    .short_frame_err (serr),
    .overrun_err     (oerr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ref_wren)    nref++;
    if (bus.diff_wren)   ndiff++;
    if (bus.frame_start) nfs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic vsync(input bit clr, input bit pix);
    bus.cam_vsync = 1'b1;
    @(negedge clk);
    bus.cam_vsync = 1'b0;
    eclr = clr;
    if (pix) begin
      bus.cam_valid = 1'b1;
      bus.cam_luma  = 8'd200;
    end
    @(negedge clk);
    eclr = 1'b0;
    bus.cam_valid = 1'b0;
    chk("frame_start", bus.frame_start, 1);
    if (pix) begin
      chk("bnd_addr", bus.ref_addr, 0);
      chk("bnd_diff_wren", bus.diff_wren, 1);
      chk("bnd_pix", bus.pixel_out, 1);
    end
    @(negedge clk);
    chk("fs_one_cycle", bus.frame_start, 0);
  endtask

  task automatic pixels(input int n, input int start, input bit c);
    int a;
    int w;
    int p;
    for (int i = 0; i < n; i++) begin
      bus.cam_valid = 1'b1;
      bus.cam_luma  = 8'((i * 8) & 255);
      @(negedge clk);
      if (c) begin
        a = (start + i < PIX) ? start + i : PIX - 1;
        w = (start + i < PIX) ? 1 : 0;
        p = (((i * 8) & 255) >= 128) ? 1 : 0;
        chk("addr", bus.ref_addr, a);
        chk("diff_addr", bus.diff_addr, a);
        chk("diff_wren", bus.diff_wren, w);
        chk("ref_en", bus.ref_bram_enable, w);
        chk("ref_wren_run", bus.ref_wren, 0);
        chk("pix_out", bus.pixel_out, p);
      end
    end
    bus.cam_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    thr = 8'd128;
    rcq = 1'b0;
    eclr = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.cam_valid = 1'b0;
    bus.cam_luma  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", st, 0);
    chk("rst_init", bus.init_done, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_wren", bus.ref_wren, 0);
    chk("rst_addr", bus.ref_addr, 0);
    chk("rst_serr", serr, 0);
    rst = 1'b0;
    @(negedge clk);

    vsync(0, 0);
    chk("st_settle", st, 1);
    repeat (3) begin
      pixels(PIX, 0, 0);
      vsync(0, 0);
    end
    chk("st_still_settle", st, 1);
    pixels(PIX, 0, 0);
    vsync(0, 0);
    chk("st_cap", st, 2);
    chk("init_lo_cap", bus.init_done, 0);
    chk("no_ref_settle", nref, 0);
    pixels(PIX, 0, 0);
    vsync(0, 0);
    chk("st_run", st, 3);
    chk("init_hi", bus.init_done, 1);
    chk("fs_count", nfs, 6);
    chk("ref_count", nref, PIX);
    chk("diff_cap", ndiff, 0);

    pixels(PIX, 0, 1);
    vsync(0, 0);
    chk("st_run2", st, 3);
    chk("serr_full", serr, 0);
    chk("diff_count", ndiff, PIX);

    pixels(PIX + 10, 0, 1);
    chk("oerr_set", oerr, 1);
    vsync(0, 0);
    chk("serr_ovr", serr, 0);
    chk("diff_count2", ndiff, 2 * PIX);
    eclr = 1'b1;
    @(negedge clk);
    eclr = 1'b0;
    chk("oerr_clr", oerr, 0);

    pixels(5, 0, 1);
    vsync(1, 0);
    chk("set_wins", serr, 1);
    eclr = 1'b1;
    @(negedge clk);
    eclr = 1'b0;
    chk("serr_clr", serr, 0);

    pixels(PIX, 0, 1);
    vsync(0, 1);
    pixels(PIX - 1, 1, 1);
    vsync(0, 0);
    chk("bnd_full", serr, 0);
    chk("st_run3", st, 3);

    pixels(10, 0, 1);
    rcq = 1'b1;
    @(negedge clk);
    rcq = 1'b0;
    pixels(PIX - 10, 10, 1);
    chk("init_hold", bus.init_done, 1);
    vsync(0, 0);
    chk("init_drop", bus.init_done, 0);
    chk("st_recap", st, 2);
    chk("serr_recap", serr, 0);

    pixels(20, 0, 0);
    vsync(0, 0);
    chk("st_short", st, 2);
    chk("serr_short", serr, 1);
    pixels(PIX, 0, 0);
    vsync(0, 0);
    chk("st_run4", st, 3);
    chk("init_hi2", bus.init_done, 1);
    eclr = 1'b1;
    @(negedge clk);
    eclr = 1'b0;
    chk("serr_clr2", serr, 0);

    pixels(10, 0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_init", bus.init_done, 0);
    chk("mid_rst_st", st, 0);
    chk("mid_rst_addr", bus.ref_addr, 0);
    chk("mid_rst_diff", bus.diff_wren, 0);
    chk("mid_rst_en", bus.ref_bram_enable, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vsync(0, 0);
    chk("rst_settle", st, 1);
    repeat (4) vsync(0, 0);
    chk("rst_cap", st, 2);
    chk("rst_init_lo", bus.init_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
